mob_tt_loader: RTL and testbench

MOB_TT_LOADER -- requirements
Module: mob_tt_loader

---
 rtl/mob_tt_loader.sv | 102 ++++++++++
 tb/tb_mob_tt_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mob_tt_loader.sv
// Truth-table loader for the Mobius transform: packs W-bit words into an N-bit table,
// presents it, then holds it stable for LOG2_N rounds. Optional zero flag: MOB_TT_LOADER_ZCHK_EN.
module mob_tt_loader #(
  parameter int N      = 64,
  parameter int LOG2_N = 6,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:W-1] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:N-1] tt_out,
  output logic         tt_valid,
  input  logic         tt_ack,
  output logic         tt_done,
  output logic         tt_zero
);

  localparam int NW = N / W;
  localparam int CW = $clog2(NW);
  localparam int HW = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  typedef enum logic [1:0] {FILL, PRESENT, HOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] word_cnt;
  logic [HW-1:0] hold_cnt;
  logic          xfer;
  logic          last_word;
  logic          fill_done;

  assign last_word = (word_cnt == CW'(NW - 1));
  assign fill_done = xfer && last_word;

  // in_ready is gated by rst_n so no word is taken while reset is held.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    tt_valid = 1'b0;
    tt_done  = 1'b0;
    xfer     = 1'b0;
    case (state)
      FILL: begin
        in_ready = rst_n;
        xfer     = in_valid && rst_n;
        if (xfer && last_word) state_nx = PRESENT;
      end
      PRESENT: begin
        tt_valid = 1'b1;
        if (tt_ack) state_nx = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          tt_done  = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      tt_out   <= '0;
    end else if (xfer) begin
      tt_out[int'(word_cnt) * W +: W] <= in_data;
      word_cnt <= last_word ? '0 : word_cnt + 1'b1;
    end
  end

  // Hold counter runs LOG2_N-1 down to 0, giving LOG2_N stable cycles after the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == PRESENT && tt_ack) begin
      hold_cnt <= HW'(LOG2_N - 1);
    end else if (state == HOLD && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef MOB_TT_LOADER_ZCHK_EN
  // The last word is still on in_data at the completing edge, so it is checked there.
  logic zero_nx;
  assign zero_nx = ~(|tt_out[0:N-W-1]) && ~(|in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tt_zero <= 1'b0;
    else if (fill_done) tt_zero <= zero_nx;
  end
`else
  assign tt_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mob_tt_loader.sv
// Directed bench for mob_tt_loader (N=64, W=8, LOG2_N=6); tt_zero expectation follows MOB_TT_LOADER_ZCHK_EN.
module tb_mob_tt_loader;

`ifdef MOB_TT_LOADER_ZCHK_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [0:7]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] tt_out;
  logic        tt_valid;
  logic        tt_ack;
  logic        tt_done;
  logic        tt_zero;

  int errors = 0;
  int checks = 0;

  mob_tt_loader #(.N(64), .LOG2_N(6), .W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tt_out   (tt_out),
    .tt_valid (tt_valid),
    .tt_ack   (tt_ack),
    .tt_done  (tt_done),
    .tt_zero  (tt_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word k of tbl is tbl[63-8k -: 8]; its MSB lands in tt_out[8k].
  task automatic load_words(input logic [63:0] tbl, input int nw, input bit gap);
    @(posedge clk); #1;
    for (int k = 0; k < nw; k++) begin
      in_data  = tbl[63-8*k -: 8];
      in_valid = 1'b1;
      @(negedge clk);
      chk("fill_tt_valid", 64'(tt_valid), 64'd0);
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Ack in PRESENT, keep ack high through HOLD (must be ignored), watch tt_done and in_ready.
  task automatic finish_table(input logic [63:0] tbl);
    tt_ack = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("hold_tt_valid", 64'(tt_valid), 64'd0);
      chk("hold_tt_done",  64'(tt_done),  64'(i == 6));
      chk("hold_in_ready", 64'(in_ready), 64'(i == 7));
      chk("hold_tt_out",   64'(tt_out),   tbl);
      if (i == 6) tt_ack = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] tbl_a;
    logic [63:0] tbl_b;
    logic [63:0] ztbl [4];
    logic        zexp [4];
    tbl_a    = 64'h8040201008040201;
    tbl_b    = 64'h0123456789abcdef;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tt_ack   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_tt_valid", 64'(tt_valid), 64'd0);
    chk("rst_tt_done",  64'(tt_done),  64'd0);
    chk("rst_tt_zero",  64'(tt_zero),  64'd0);
    chk("rst_tt_out",   64'(tt_out),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back load, then a long PRESENT with in_valid toggling.
    load_words(tbl_a, 8, 1'b0);
    @(negedge clk);
    chk("b2b_tt_valid", 64'(tt_valid), 64'd1);
    chk("b2b_in_ready", 64'(in_ready), 64'd0);
    chk("b2b_tt_out",   64'(tt_out),   tbl_a);
    chk("b2b_tt_done",  64'(tt_done),  64'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_data  = 8'($urandom);
      @(negedge clk);
      chk("present_tt_out",   64'(tt_out),   tbl_a);
      chk("present_in_ready", 64'(in_ready), 64'd0);
      chk("present_tt_valid", 64'(tt_valid), 64'd1);
    end
    in_valid = 1'b0;
    finish_table(tbl_a);

    // Gapped load produces the same table.
    load_words(tbl_a, 8, 1'b1);
    @(negedge clk);
    chk("gap_tt_valid", 64'(tt_valid), 64'd1);
    chk("gap_tt_out",   64'(tt_out),   tbl_a);
    finish_table(tbl_a);

    // Reset after 5 words, then a fresh table.
    load_words(64'hffffffffffffffff, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_tt_out",   64'(tt_out),   64'd0);
    chk("midfill_rst_in_ready", 64'(in_ready), 64'd0);
    chk("midfill_rst_tt_valid", 64'(tt_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midfill_rel_in_ready", 64'(in_ready), 64'd1);
    load_words(tbl_b, 8, 1'b0);
    @(negedge clk);
    chk("fresh_tt_valid", 64'(tt_valid), 64'd1);
    chk("fresh_tt_out",   64'(tt_out),   tbl_b);
    finish_table(tbl_b);

    // Zero flag, including a table whose only set bit is in the last word.
    ztbl[0] = 64'h0;                zexp[0] = ZEN;
    ztbl[1] = 64'h0000000000000001; zexp[1] = 1'b0;
    ztbl[2] = 64'h0;                zexp[2] = ZEN;
    ztbl[3] = 64'h0100000000000000; zexp[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      load_words(ztbl[t], 8, 1'b0);
      @(negedge clk);
      chk("zero_tt_valid", 64'(tt_valid), 64'd1);
      chk("zero_tt_out",   64'(tt_out),   ztbl[t]);
      chk("zero_tt_zero",  64'(tt_zero),  64'(zexp[t]));
      finish_table(ztbl[t]);
      chk("zero_held",     64'(tt_zero),  64'(zexp[t]));
    end

    // Reset during HOLD cycle 3 aborts the hold without tt_done.
    load_words(tbl_a, 8, 1'b0);
    @(negedge clk);
    chk("abort_tt_valid", 64'(tt_valid), 64'd1);
    tt_ack = 1'b1;
    @(posedge clk); #1;
    tt_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_tt_done", 64'(tt_done), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_tt_out",   64'(tt_out),   64'd0);
    chk("abort_tt_done",  64'(tt_done),  64'd0);
    chk("abort_tt_valid2",64'(tt_valid), 64'd0);
    chk("abort_tt_zero",  64'(tt_zero),  64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_rst_tt_done",  64'(tt_done),  64'd0);
      chk("abort_rst_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_in_ready", 64'(in_ready), 64'd1);
    repeat (8) begin
      @(negedge clk);
      chk("abort_idle_tt_done",  64'(tt_done),  64'd0);
      chk("abort_idle_in_ready", 64'(in_ready), 64'd1);
      chk("abort_idle_tt_valid", 64'(tt_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
